// File: rtl/term_pkg.sv
// Shared constants, state encoding and row arithmetic for the serial text terminal.
package term_pkg;

    localparam int unsigned COLS  = 60;
    localparam int unsigned ROWS  = 17;
    localparam logic [7:0]  BLANK = 8'h20;

    // Control codes recognised by the terminal controller
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [1:0] {
        StClearAll,
        StIdle,
        StPut,
        StClearLine
    } state_e;

    // (a + b) mod ROWS for a, b < ROWS, without a divider
    function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(ROWS)) begin
            s = s - 6'(ROWS);
        end
        return s[4:0];
    endfunction

endpackage

// File: rtl/term_fill_seq.sv
// Row/column sweep counter shared by the full-screen and single-row clears.
// While a sweep runs, o_row/o_col give the cell to write in the current cycle;
// on the start cycle they already show the first cell. o_done pulses the cycle
// after the last cell was presented. Out of reset a full-screen sweep is armed.
module term_fill_seq
    import term_pkg::*;
#(
    parameter int unsigned N_COLS = COLS,
    parameter int unsigned N_ROWS = ROWS
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_full,
    input  logic [4:0] i_row,
    output logic [4:0] o_row,
    output logic [5:0] o_col,
    output logic       o_done
);

    localparam logic [5:0] LAST_COL = 6'(N_COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(N_ROWS - 1);

    logic [4:0] row_q;
    logic [5:0] col_q;
    logic       busy_q;
    logic       full_q;
    logic       done_q;

    logic       active;
    logic       full;
    logic       last;

    // Current cell: the start cell on a start cycle, otherwise the counter
    always_comb begin
        active = i_start | busy_q;
        full   = i_start ? i_full : full_q;
        if (i_start) begin
            o_row = i_full ? 5'd0 : i_row;
            o_col = 6'd0;
        end else begin
            o_row = row_q;
            o_col = col_q;
        end
        last = (o_col == LAST_COL) && (!full || (o_row == LAST_ROW));
    end

    assign o_done = done_q;

    // Advance one cell per cycle while a sweep is active
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_q  <= 5'd0;
            col_q  <= 6'd0;
            busy_q <= 1'b1;
            full_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= active & last;
            if (active) begin
                full_q <= full;
                busy_q <= !last;
                if (o_col == LAST_COL) begin
                    col_q <= 6'd0;
                    row_q <= o_row + 5'd1;
                end else begin
                    col_q <= o_col + 6'd1;
                    row_q <= o_row;
                end
            end
        end
    end

endmodule

// File: rtl/term_ctrl.sv
// Terminal controller: decodes received bytes, owns cursor and scroll pointer,
// and sequences every write into the character VRAM.
module term_ctrl #(
    parameter int unsigned COLS  = term_pkg::COLS,
    parameter int unsigned ROWS  = term_pkg::ROWS,
    parameter logic [7:0]  BLANK = term_pkg::BLANK
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_we,
    output logic [10:0] o_waddr,
    output logic [7:0]  o_wdata,
    output logic [4:0]  o_top_row,
    output logic [5:0]  o_cur_x,
    output logic [4:0]  o_cur_y
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    term_pkg::state_e state;
    logic             put_adv;  // PUT came from a printable byte, so the cursor advances

    logic       accept;
    logic [4:0] phys;
    logic [4:0] next_top;
    logic       at_last_row;
    logic       put_wraps;

    logic       seq_start;
    logic       seq_full;
    logic [4:0] seq_row_in;
    logic [4:0] seq_row;
    logic [5:0] seq_col;
    logic       seq_done;

    assign accept      = i_valid & o_ready;
    assign phys        = term_pkg::row_add(o_top_row, o_cur_y);
    assign next_top    = term_pkg::row_add(o_top_row, 5'd1);
    assign at_last_row = (o_cur_y == LAST_ROW);
    assign put_wraps   = put_adv & (o_cur_x == LAST_COL);

    // Kick the sweep on FF, or on a newline that scrolls; the row cleared is
    // the current top row, which becomes the new bottom row
    always_comb begin
        seq_start  = 1'b0;
        seq_full   = 1'b0;
        seq_row_in = o_top_row;
        case (state)
            term_pkg::StIdle: begin
                if (accept) begin
                    if (i_data == term_pkg::FF) begin
                        seq_start = 1'b1;
                        seq_full  = 1'b1;
                    end else if ((i_data == term_pkg::LF) && at_last_row) begin
                        seq_start = 1'b1;
                    end
                end
            end
            term_pkg::StPut: begin
                if (put_wraps && at_last_row) begin
                    seq_start = 1'b1;
                end
            end
            default: ;
        endcase
    end

    term_fill_seq #(
        .N_COLS(COLS),
        .N_ROWS(ROWS)
    ) u_fill (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(seq_start),
        .i_full (seq_full),
        .i_row  (seq_row_in),
        .o_row  (seq_row),
        .o_col  (seq_col),
        .o_done (seq_done)
    );

    // Controller FSM with registered write port, cursor and scroll pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= term_pkg::StClearAll;
            put_adv   <= 1'b0;
            o_ready   <= 1'b0;
            o_we      <= 1'b0;
            o_waddr   <= 11'd0;
            o_wdata   <= BLANK;
            o_top_row <= 5'd0;
            o_cur_x   <= 6'd0;
            o_cur_y   <= 5'd0;
        end else begin
            o_we <= 1'b0;
            case (state)
                term_pkg::StClearAll, term_pkg::StClearLine: begin
                    if (seq_done) begin
                        state   <= term_pkg::StIdle;
                        o_ready <= 1'b1;
                        if (state == term_pkg::StClearAll) begin
                            o_cur_x   <= 6'd0;
                            o_cur_y   <= 5'd0;
                            o_top_row <= 5'd0;
                        end
                    end else begin
                        o_we    <= 1'b1;
                        o_waddr <= {seq_row, seq_col};
                        o_wdata <= BLANK;
                    end
                end

                term_pkg::StIdle: begin
                    if (accept) begin
                        if (i_data == term_pkg::CR) begin
                            o_cur_x <= 6'd0;
                        end else if (i_data == term_pkg::LF) begin
                            o_cur_x <= 6'd0;
                            if (!at_last_row) begin
                                o_cur_y <= o_cur_y + 5'd1;
                            end else begin
                                o_top_row <= next_top;
                                state     <= term_pkg::StClearLine;
                                o_ready   <= 1'b0;
                                o_we      <= 1'b1;
                                o_waddr   <= {seq_row, seq_col};
                                o_wdata   <= BLANK;
                            end
                        end else if (i_data == term_pkg::BS) begin
                            if (o_cur_x != 6'd0) begin
                                o_cur_x <= o_cur_x - 6'd1;
                                o_we    <= 1'b1;
                                o_waddr <= {phys, o_cur_x - 6'd1};
                                o_wdata <= BLANK;
                                put_adv <= 1'b0;
                                state   <= term_pkg::StPut;
                                o_ready <= 1'b0;
                            end
                        end else if (i_data == term_pkg::FF) begin
                            state   <= term_pkg::StClearAll;
                            o_ready <= 1'b0;
                            o_we    <= 1'b1;
                            o_waddr <= {seq_row, seq_col};
                            o_wdata <= BLANK;
                        end else if (i_data >= 8'h20) begin
                            o_we    <= 1'b1;
                            o_waddr <= {phys, o_cur_x};
                            o_wdata <= i_data;
                            put_adv <= 1'b1;
                            state   <= term_pkg::StPut;
                            o_ready <= 1'b0;
                        end
                    end
                end

                term_pkg::StPut: begin
                    if (put_wraps) begin
                        o_cur_x <= 6'd0;
                        if (!at_last_row) begin
                            o_cur_y <= o_cur_y + 5'd1;
                            state   <= term_pkg::StIdle;
                            o_ready <= 1'b1;
                        end else begin
                            o_top_row <= next_top;
                            state     <= term_pkg::StClearLine;
                            o_we      <= 1'b1;
                            o_waddr   <= {seq_row, seq_col};
                            o_wdata   <= BLANK;
                        end
                    end else begin
                        if (put_adv) begin
                            o_cur_x <= o_cur_x + 6'd1;
                        end
                        state   <= term_pkg::StIdle;
                        o_ready <= 1'b1;
                    end
                end

                default: state <= term_pkg::StClearAll;
            endcase
        end
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: directed timing steps plus random byte streams checked
// against a screen-level reference model.
module tb_term_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_we;
    logic [10:0] o_waddr;
    logic [7:0]  o_wdata;
    logic [4:0]  o_top_row;
    logic [5:0]  o_cur_x;
    logic [4:0]  o_cur_y;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    term_ctrl dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_we     (o_we),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_top_row(o_top_row),
        .o_cur_x  (o_cur_x),
        .o_cur_y  (o_cur_y)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] dut_mem [0:31][0:63];
    logic [7:0] ref_mem [0:31][0:63];
    int mx, my, mtop;

    int          wr_cnt = 0;
    int          first_wr_cyc = -1;
    int          last_wr_cyc = -1;
    int          bad_col = 0;
    logic [10:0] first_waddr = '0;
    logic [10:0] last_waddr = '0;

    // Write monitor: samples 3 time units after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (o_we === 1'b1) begin
                dut_mem[o_waddr[10:6]][o_waddr[5:0]] = o_wdata;
                if (wr_cnt == 0) begin
                    first_wr_cyc = cyc;
                    first_waddr  = o_waddr;
                end
                last_wr_cyc = cyc;
                last_waddr  = o_waddr;
                wr_cnt++;
                if (o_waddr[5:0] >= 6'd60) bad_col++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt       = 0;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
    endtask

    // Reference model: the screen as rows of characters with a scroll offset
    task automatic ref_clear();
        for (int r = 0; r < 17; r++)
            for (int c = 0; c < 60; c++) ref_mem[r][c] = 8'h20;
        mx = 0; my = 0; mtop = 0;
    endtask

    task automatic ref_newline();
        mx = 0;
        if (my < 16) my++;
        else begin
            mtop = (mtop + 1) % 17;
            for (int c = 0; c < 60; c++) ref_mem[(mtop + 16) % 17][c] = 8'h20;
        end
    endtask

    task automatic ref_byte(input logic [7:0] b);
        if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) ref_newline();
        else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                ref_mem[(mtop + my) % 17][mx] = 8'h20;
            end
        end else if (b == 8'h0C) ref_clear();
        else if (b >= 8'h20) begin
            ref_mem[(mtop + my) % 17][mx] = b;
            if (mx == 59) ref_newline();
            else mx++;
        end
    endtask

    function automatic logic [10:0] ref_addr(input int col);
        logic [4:0] r;
        logic [5:0] c;
        r = 5'((mtop + my) % 17);
        c = 6'(col);
        return {r, c};
    endfunction

    // Returns at the falling edge of the cycle after acceptance
    task automatic send(input logic [7:0] b, output int acc);
        int n = 0;
        while (o_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) chk("send_ready_timeout", 32'(o_ready), 1);
        i_data  = b;
        i_valid = 1'b1;
        acc     = cyc + 1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = $urandom_range(0, 255);
        @(negedge clk);
        ref_byte(b);
    endtask

    task automatic wait_idle(output int at);
        int n = 0;
        while (o_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) chk("idle_timeout", 32'(o_ready), 1);
        at = cyc;
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int r = 0; r < 17; r++)
            for (int c = 0; c < 64; c++)
                if (dut_mem[r][c] !== ref_mem[r][c]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_x"}, 32'(o_cur_x), mx);
        chk({tag, "_y"}, 32'(o_cur_y), my);
        chk({tag, "_top"}, 32'(o_top_row), mtop);
    endtask

    initial begin
        int a, t, rel, r, n;
        logic [7:0] b;
        logic [10:0] e;

        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 64; j++) begin
                dut_mem[i][j] = 8'h00;
                ref_mem[i][j] = 8'h00;
            end
        rst = 1'b1; i_valid = 1'b0; i_data = 8'h00;
        repeat (4) @(negedge clk);

        // Reset values
        chk("rst_we", 32'(o_we), 0);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_waddr", 32'(o_waddr), 0);
        chk("rst_wdata", 32'(o_wdata), 32'h20);
        chk("rst_top", 32'(o_top_row), 0);
        chk("rst_cur_x", 32'(o_cur_x), 0);
        chk("rst_cur_y", 32'(o_cur_y), 0);

        // Power-up clear
        ref_clear();
        clear_log();
        rel = cyc + 1;
        rst = 1'b0;
        wait_idle(t);
        chk("init_first_cyc", first_wr_cyc, rel);
        chk("init_first_addr", 32'(first_waddr), 0);
        chk("init_wr_cnt", wr_cnt, 1020);
        chk("init_last_addr", 32'(last_waddr), 32'({5'd16, 6'd59}));
        chk("init_ready_rise", t, last_wr_cyc + 1);
        chk_cursor("init");
        mem_compare("init_vram");

        // Single printable byte
        send(8'h41, a);
        chk("A_we", 32'(o_we), 1);
        chk("A_addr", 32'(o_waddr), 0);
        chk("A_data", 32'(o_wdata), 32'h41);
        chk("A_ready_low", 32'(o_ready), 0);
        @(negedge clk);
        chk("A_ready_back", 32'(o_ready), 1);
        chk("A_cur_x", 32'(o_cur_x), 1);
        chk("A_we_off", 32'(o_we), 0);

        // CR keeps the controller ready
        send(8'h0D, a);
        chk("CR_ready", 32'(o_ready), 1);
        chk("CR_x", 32'(o_cur_x), 0);

        // A full row wraps the cursor
        clear_log();
        for (int i = 0; i < 60; i++) send(8'(8'h40 + i), a);
        wait_idle(t);
        chk("row0_wr_cnt", wr_cnt, 60);
        chk("row0_last_addr", 32'(last_waddr), 32'({5'd0, 6'd59}));
        chk("row0_cur_x", 32'(o_cur_x), 0);
        chk("row0_cur_y", 32'(o_cur_y), 1);

        // Fill to the bottom-right cell
        for (int i = 0; i < 959; i++) send(8'($urandom_range(32, 255)), a);
        wait_idle(t);
        chk("fill_cur_x", 32'(o_cur_x), 59);
        chk("fill_cur_y", 32'(o_cur_y), 16);

        // Printable byte at the last cell scrolls
        clear_log();
        send(8'h42, a);
        chk("scr_put_addr", 32'(o_waddr), 32'({5'd16, 6'd59}));
        chk("scr_put_data", 32'(o_wdata), 32'h42);
        @(negedge clk);
        chk("scr_top", 32'(o_top_row), 1);
        chk("scr_clr_we", 32'(o_we), 1);
        chk("scr_clr_addr", 32'(o_waddr), 0);
        wait_idle(t);
        chk("scr_wr_cnt", wr_cnt, 61);
        chk("scr_first_cyc", first_wr_cyc, a);
        chk("scr_last_cyc", last_wr_cyc, a + 60);
        chk("scr_ready_cyc", t, a + 61);
        chk("scr_last_addr", 32'(last_waddr), 32'({5'd0, 6'd59}));
        chk_cursor("scr");
        mem_compare("scr_vram");

        // CR, LF, Z
        send(8'h0D, a);
        send(8'h0A, a);
        wait_idle(t);
        e = ref_addr(mx);
        send(8'h5A, a);
        chk("Z_addr", 32'(o_waddr), 32'(e));
        chk("Z_data", 32'(o_wdata), 32'h5A);
        wait_idle(t);
        chk_cursor("Z");

        // Backspace at column 0 and at column 5
        send(8'h0D, a);
        clear_log();
        send(8'h08, a);
        chk("BS0_we", 32'(o_we), 0);
        chk("BS0_ready", 32'(o_ready), 1);
        chk("BS0_x", 32'(o_cur_x), 0);
        @(negedge clk);
        chk("BS0_wr_cnt", wr_cnt, 0);
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i), a);
        wait_idle(t);
        send(8'h08, a);
        chk("BS5_we", 32'(o_we), 1);
        chk("BS5_addr", 32'(o_waddr), 32'(ref_addr(4)));
        chk("BS5_data", 32'(o_wdata), 32'h20);
        @(negedge clk);
        chk("BS5_x", 32'(o_cur_x), 4);
        mem_compare("bs_vram");

        // FF with a non-zero scroll pointer
        send(8'h0A, a);
        wait_idle(t);
        send(8'h68, a);
        send(8'h69, a);
        wait_idle(t);
        chk("ff_pre_top", 32'(o_top_row), 3);
        clear_log();
        send(8'h0C, a);
        chk("ff_first_we", 32'(o_we), 1);
        chk("ff_first_addr", 32'(o_waddr), 0);
        wait_idle(t);
        chk("ff_first_cyc", first_wr_cyc, a);
        chk("ff_wr_cnt", wr_cnt, 1020);
        chk("ff_last_addr", 32'(last_waddr), 32'({5'd16, 6'd59}));
        chk("ff_ready_rise", t, last_wr_cyc + 1);
        chk_cursor("ff");
        mem_compare("ff_vram");

        // Reset during a sweep restarts it
        send(8'h41, a);
        clear_log();
        send(8'h0C, a);
        n = 0;
        while (wr_cnt < 500 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wr_cnt", wr_cnt, 500);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_we", 32'(o_we), 0);
        ref_clear();
        clear_log();
        rel = cyc + 1;
        rst = 1'b0;
        wait_idle(t);
        chk("mid_first_cyc", first_wr_cyc, rel);
        chk("mid_first_addr", 32'(first_waddr), 0);
        chk("mid_wr_cnt_full", wr_cnt, 1020);
        chk_cursor("mid");
        mem_compare("mid_vram");

        // Random byte stream against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65) b = 8'($urandom_range(32, 255));
            else if (r < 73) b = 8'h0D;
            else if (r < 83) b = 8'h0A;
            else if (r < 91) b = 8'h08;
            else if (r < 99) begin
                do b = 8'($urandom_range(0, 31));
                while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
            end else b = 8'h0C;
            send(b, a);
            wait_idle(t);
            chk_cursor("rnd");
        end
        mem_compare("rnd_vram");
        chk("never_col_60_63", bad_col, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
